// File: rtl/seq110_pkg.sv
// Shared types for the "110" detector scheduler: scheduler states, detector
// state encodings and the detector next-state function.
package seq110_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_SHIFT = 2'b01,
      ST_DONE  = 2'b10
   } sched_state_t;

   localparam logic [1:0] S0 = 2'b00;
   localparam logic [1:0] S1 = 2'b01;
   localparam logic [1:0] S2 = 2'b10;

   // S0 = nothing seen, S1 = "1" seen, S2 = "11" seen (sticky on further 1s).
   function automatic logic [1:0] det_next(input logic [1:0] st, input logic bit_in);
      logic [1:0] nxt;
      nxt = S0;
      case (st)
         S0:      nxt = bit_in ? S1 : S0;
         S1:      nxt = bit_in ? S2 : S0;
         S2:      nxt = bit_in ? S2 : S0;
         default: nxt = S0;
      endcase
      return nxt;
   endfunction

endpackage

// File: rtl/seq110_core.sv
// Bit-serial Mealy "110" detector with a synchronous clear so each word
// starts from S0.
module seq110_core
   import seq110_pkg::*;
(
   input  logic clk,
   input  logic reset_n,
   input  logic clr,
   input  logic in,
   output logic detect
);

   logic [1:0] state_q;
   logic [1:0] state_d;

   always_comb begin
      state_d = clr ? S0 : det_next(state_q, in);
   end

   assign detect = (state_q == S2) && !in;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S0;
      end else begin
         state_q <= state_d;
      end
   end

endmodule

// File: rtl/seq110_sched.sv
// Round-robin two-source scheduler feeding one shared "110" detector; each
// accepted word is shifted MSB-first and its detection count is returned.
module seq110_sched
   import seq110_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int CNT_W  = 4
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              req0_valid,
   input  logic [DATA_W-1:0] req0_data,
   output logic              req0_ready,
   input  logic              req1_valid,
   input  logic [DATA_W-1:0] req1_data,
   output logic              req1_ready,
   output logic              res_valid,
   input  logic              res_ready,
   output logic              res_src,
   output logic [CNT_W-1:0]  res_count,
   output logic              busy
);

   localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

   sched_state_t      state_q, state_d;
   logic              last_grant_q, last_grant_d;
   logic [DATA_W-1:0] word_q, word_d;
   logic              src_q, src_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic              res_valid_q, res_valid_d;
   logic              busy_q, busy_d;

   logic gnt0;
   logic gnt1;
   logic core_in;
   logic core_clr;
   logic det;

   // Handshakes: a transfer happens on a rising edge where valid and ready are
   // both 1. Requesters hold valid until ready; res_valid stays up until res_ready.
   always_comb begin
      gnt0 = (state_q == ST_IDLE) && req0_valid && (!req1_valid || last_grant_q);
      gnt1 = (state_q == ST_IDLE) && req1_valid && (!req0_valid || !last_grant_q);
   end

   assign req0_ready = gnt0;
   assign req1_ready = gnt1;
   assign core_clr   = gnt0 | gnt1;
   assign core_in    = (state_q == ST_SHIFT) ? word_q[idx_q] : 1'b0;

   seq110_core u_core (
      .clk     (clk),
      .reset_n (reset_n),
      .clr     (core_clr),
      .in      (core_in),
      .detect  (det)
   );

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      word_d       = word_q;
      src_d        = src_q;
      cnt_d        = cnt_q;
      idx_d        = idx_q;
      res_valid_d  = res_valid_q;
      busy_d       = busy_q;
      case (state_q)
         ST_IDLE: begin
            if (gnt0 || gnt1) begin
               word_d       = gnt1 ? req1_data : req0_data;
               src_d        = gnt1;
               last_grant_d = gnt1;
               cnt_d        = '0;
               idx_d        = IDX_LAST;
               busy_d       = 1'b1;
               state_d      = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            if (det) begin
               cnt_d = cnt_q + CNT_W'(1);
            end
            if (idx_q == '0) begin
               res_valid_d = 1'b1;
               state_d     = ST_DONE;
            end else begin
               idx_d = idx_q - IDX_W'(1);
            end
         end
         ST_DONE: begin
            if (res_ready) begin
               res_valid_d = 1'b0;
               busy_d      = 1'b0;
               state_d     = ST_IDLE;
            end
         end
         default: begin
            res_valid_d = 1'b0;
            busy_d      = 1'b0;
            state_d     = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= ST_IDLE;
         last_grant_q <= 1'b1;
         word_q       <= '0;
         src_q        <= 1'b0;
         cnt_q        <= '0;
         idx_q        <= '0;
         res_valid_q  <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         word_q       <= word_d;
         src_q        <= src_d;
         cnt_q        <= cnt_d;
         idx_q        <= idx_d;
         res_valid_q  <= res_valid_d;
         busy_q       <= busy_d;
      end
   end

   assign res_valid = res_valid_q;
   assign res_src   = src_q;
   assign res_count = cnt_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_seq110_sched.sv
// Directed bench for seq110_sched: hand-computed counts, latency, arbitration,
// backpressure and mid-word reset.
module tb_seq110_sched;

   localparam int DATA_W = 8;
   localparam int CNT_W  = 4;
   localparam int LAT    = DATA_W + 1;

   logic              clk;
   logic              reset_n;
   logic              req0_valid;
   logic [DATA_W-1:0] req0_data;
   logic              req0_ready;
   logic              req1_valid;
   logic [DATA_W-1:0] req1_data;
   logic              req1_ready;
   logic              res_valid;
   logic              res_ready;
   logic              res_src;
   logic [CNT_W-1:0]  res_count;
   logic              busy;

   logic [CNT_W:0] exp_q[$];
   int n_tests;
   int n_fail;

   seq110_sched #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .req0_valid (req0_valid),
      .req0_data  (req0_data),
      .req0_ready (req0_ready),
      .req1_valid (req1_valid),
      .req1_data  (req1_data),
      .req1_ready (req1_ready),
      .res_valid  (res_valid),
      .res_ready  (res_ready),
      .res_src    (res_src),
      .res_count  (res_count),
      .busy       (busy)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_r0"}, 32'(req0_ready), 32'd0);
      check({tag, "_r1"}, 32'(req1_ready), 32'd0);
      check({tag, "_vld"}, 32'(res_valid), 32'd0);
      check({tag, "_src"}, 32'(res_src), 32'd0);
      check({tag, "_cnt"}, 32'(res_count), 32'd0);
      check({tag, "_busy"}, 32'(busy), 32'd0);
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      step();
      step();
      reset_n = 1'b1;
      step();
   endtask

   // driver: offer one word from one source, return after the acceptance edge
   task automatic send(input logic src, input logic [DATA_W-1:0] data,
                       input logic [CNT_W-1:0] exp_cnt, input logic push);
      int n;
      if (src) begin req1_valid = 1'b1; req1_data = data; end
      else     begin req0_valid = 1'b1; req0_data = data; end
      #1;
      n = 0;
      while (!(src ? req1_ready : req0_ready) && n < 40) begin
         step();
         n++;
      end
      check("accept", 32'(src ? req1_ready : req0_ready), 32'd1);
      check("other_ready", 32'(src ? req0_ready : req1_ready), 32'd0);
      if (push) exp_q.push_back({src, exp_cnt});
      step();
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      req0_data  = ~data;
      req1_data  = ~data;
   endtask

   // scoreboard: called just after an acceptance edge (or with res_valid up)
   task automatic get_result(input int lat_exp);
      int n;
      logic [CNT_W:0] e;
      n = 1;
      while (!res_valid && n < 40) begin
         step();
         n++;
      end
      check("res_valid", 32'(res_valid), 32'd1);
      if (lat_exp > 0) check("latency", 32'(n), 32'(lat_exp));
      if (exp_q.size() == 0) begin
         check("exp_q_empty", 32'd1, 32'd0);
      end else begin
         e = exp_q.pop_front();
         check("res_src", 32'(res_src), 32'(e[CNT_W]));
         check("res_count", 32'(res_count), 32'(e[CNT_W-1:0]));
      end
      res_ready = 1'b1;
      step();
      check("res_drop", 32'(res_valid), 32'd0);
   endtask

   initial begin
      n_tests = 0;
      n_fail = 0;
      reset_n = 1'b0;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      req0_data = '0;
      req1_data = '0;
      res_ready = 1'b1;
      step();
      check_all_zero("reset");
      reset_n = 1'b1;
      step();

      // single source words; 0x6C=01101100 -> 2, with latency check
      send(1'b0, 8'h6C, 4'd2, 1'b1);
      check("busy_shift", 32'(busy), 32'd1);
      get_result(LAT);
      // 11010110 -> 2, all ones -> 0, all zeros -> 0
      send(1'b1, 8'hD6, 4'd2, 1'b1);
      get_result(LAT);
      send(1'b1, 8'hFF, 4'd0, 1'b1);
      get_result(LAT);
      send(1'b1, 8'h00, 4'd0, 1'b1);
      get_result(LAT);
      // trailing "11" must not combine with the next word's leading 0
      send(1'b0, 8'h03, 4'd0, 1'b1);
      get_result(LAT);
      send(1'b0, 8'h00, 4'd0, 1'b1);
      get_result(LAT);

      // fresh reset, both valid held: grants 0,1,0,1
      do_reset();
      req0_valid = 1'b1; req0_data = 8'hEE;
      req1_valid = 1'b1; req1_data = 8'h66;
      for (int i = 0; i < 4; i++) begin
         int n;
         #1;
         n = 0;
         while (!(req0_ready || req1_ready) && n < 40) begin
            step();
            n++;
         end
         check("tie_r0", 32'(req0_ready), 32'((i % 2) == 0));
         check("tie_r1", 32'(req1_ready), 32'((i % 2) == 1));
         exp_q.push_back({((i % 2) == 1), 4'd2});
         step();
         check("ready_pulse", 32'(req0_ready | req1_ready), 32'd0);
         get_result(LAT);
      end

      // backpressure in DONE with both valids still pending
      res_ready = 1'b0;
      #1;
      check("bp_grant", 32'(req0_ready), 32'd1);
      exp_q.push_back({1'b0, 4'd2});
      step();
      begin
         int n;
         n = 1;
         while (!res_valid && n < 40) begin
            step();
            n++;
         end
      end
      for (int k = 0; k < 5; k++) begin
         check("bp_vld", 32'(res_valid), 32'd1);
         check("bp_src", 32'(res_src), 32'd0);
         check("bp_cnt", 32'(res_count), 32'd2);
         check("bp_nogrant", 32'(req0_ready | req1_ready), 32'd0);
         step();
      end
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      get_result(0);

      // reset asserted in the 4th SHIFT cycle discards the word
      send(1'b0, 8'h6C, 4'd2, 1'b0);
      step();
      step();
      step();
      check("pre_rst_busy", 32'(busy), 32'd1);
      reset_n = 1'b0;
      #1;
      check_all_zero("midrst");
      step();
      reset_n = 1'b1;
      step();
      check("post_rst_idle", 32'(busy), 32'd0);
      req0_valid = 1'b1; req0_data = 8'hD6;
      req1_valid = 1'b1; req1_data = 8'h03;
      #1;
      check("rst_tie_r0", 32'(req0_ready), 32'd1);
      check("rst_tie_r1", 32'(req1_ready), 32'd0);
      exp_q.push_back({1'b0, 4'd2});
      step();
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      req0_data  = 8'h00;
      get_result(LAT);
      check("exp_q_drained", 32'(exp_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
